data_memory_mp: RTL and testbench

Parametrised successor to the team's 2-read/1-write data memory. It has a generic width and depth, per-byte write enables, and registered reads with a read-valid strobe. A built-in clear sequencer zeroes every entry after reset or on software request. It sits beside the register file and ALU datapath as the scratch data store.

---
 rtl/data_memory_mp.sv | 123 ++++++++++++
 tb/tb_data_memory_mp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_mp.sv
// Parametrised 2-read/1-write scratch data memory with byte enables, registered reads
// and a clear sequencer. Define DMEM_BYPASS_EN for write-first read-during-write.
module data_memory_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   read1,
    input  logic [ADDR_W-1:0]   read2,
    input  logic [ADDR_W-1:0]   write,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic                re,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                clear_req,
    output logic [DATA_W-1:0]   data_out1,
    output logic [DATA_W-1:0]   data_out2,
    output logic                rd_valid,
    output logic                busy,
    output logic                addr_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok, r1_ok, r2_ok;
    logic [DATA_W-1:0] old_word, merged, rd1_word, rd2_word;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BYTES-1:0]  en
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BYTES; i++) begin
            if (en[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Range checks widen by one bit so DEPTH == 2^ADDR_W never flags.
    assign wr_ok    = {1'b0, write} < DEPTH_L;
    assign r1_ok    = {1'b0, read1} < DEPTH_L;
    assign r2_ok    = {1'b0, read2} < DEPTH_L;
    assign old_word = mem[write[IDX_W-1:0]];
    assign merged   = byte_merge(old_word, data_in, be);

`ifdef DMEM_BYPASS_EN
    assign rd1_word = (we && wr_ok && read1 == write) ? merged : mem[read1[IDX_W-1:0]];
    assign rd2_word = (we && wr_ok && read2 == write) ? merged : mem[read2[IDX_W-1:0]];
`else
    assign rd1_word = mem[read1[IDX_W-1:0]];
    assign rd2_word = mem[read2[IDX_W-1:0]];
`endif

    // Storage is never reset; the sequencer zeroes it once reset releases.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[cnt[IDX_W-1:0]] <= '0;
            end else if (we && wr_ok) begin
                mem[write[IDX_W-1:0]] <= merged;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            busy      <= 1'b1;
            data_out1 <= '0;
            data_out2 <= '0;
            rd_valid  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    data_out1 <= '0;
                    data_out2 <= '0;
                    rd_valid  <= 1'b0;
                    addr_err  <= 1'b0;
                    if (cnt == LAST) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    addr_err <= (we && !wr_ok) || (re && (!r1_ok || !r2_ok));
                    if (re) begin
                        data_out1 <= r1_ok ? rd1_word : '0;
                        data_out2 <= r2_ok ? rd2_word : '0;
                        rd_valid  <= 1'b1;
                    end else begin
                        data_out1 <= '0;
                        data_out2 <= '0;
                        rd_valid  <= 1'b0;
                    end
                    // The access of this cycle completes before the clear begins.
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_mp.sv
// Directed self-checking bench for data_memory_mp (DEPTH=16, ADDR_W=5, DATA_W=32).
module tb_data_memory_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read1, read2, write;
    logic        we, re, clear_req;
    logic [3:0]  be;
    logic [31:0] data_in;
    logic [31:0] data_out1, data_out2;
    logic        rd_valid, busy, addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .read1(read1), .read2(read2), .write(write),
        .we(we), .be(be), .re(re), .data_in(data_in), .clear_req(clear_req),
        .data_out1(data_out1), .data_out2(data_out2), .rd_valid(rd_valid),
        .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        we = 0; re = 0; clear_req = 0; be = 4'h0; data_in = '0;
        write = '0; read1 = '0; read2 = '0;
    endtask

    // Counts edges until busy drops, bounded so a stuck sequencer still reaches the summary.
    task automatic count_busy(output int n, output logic rv_seen);
        n = 0;
        rv_seen = 1'b0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (rd_valid) rv_seen = 1'b1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1; write = a; data_in = d; be = b;
        tick();
        we = 0;
    endtask

    logic [31:0] model [16];
    int          n;
    logic        rv_seen;
    logic [31:0] exp_byp;

    initial begin
        idle();
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset state
        reset = 1;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_outs", {rd_valid, addr_err, data_out1, data_out2}, 64'd0);

        // Clear after release lasts exactly DEPTH cycles
        reset = 0;
        check("post_rel_busy", 64'(busy), 64'd1);
        count_busy(n, rv_seen);
        check("init_clear_len", 64'(n), 64'd16);
        check("init_clear_rv", 64'(rv_seen), 64'd0);

        for (int a = 0; a < 16; a++) begin
            re = 1; read1 = 5'(a); read2 = 5'(a);
            tick();
            check($sformatf("clr_rd_%0d", a), {rd_valid, data_out1, data_out2[30:0]}, {1'b1, 63'd0});
        end
        re = 0;
        tick();
        check("re_low_zero", {rd_valid, data_out1}, 64'd0);

        // Byte-enable merge, both ports same address
        wr(5'd0, 32'h0000000F, 4'hF);
        wr(5'd0, 32'hAABBCCDD, 4'b0101);
        model[0] = 32'h00BB00DD;
        re = 1; read1 = 0; read2 = 0;
        tick();
        check("be_merge_p1", 64'(data_out1), 64'h00BB00DD);
        check("be_merge_p2", 64'(data_out2), 64'h00BB00DD);
        re = 0;

        // Read during write to the same address
        wr(5'd3, 32'h00000007, 4'hF);
`ifdef DMEM_BYPASS_EN
        exp_byp = 32'h12345678;
`else
        exp_byp = 32'h00000007;
`endif
        we = 1; write = 3; data_in = 32'h12345678; be = 4'hF;
        re = 1; read1 = 3; read2 = 0;
        tick();
        we = 0;
        check("rdw_p1", 64'(data_out1), 64'(exp_byp));
        check("rdw_p2", 64'(data_out2), 64'h00BB00DD);
        model[3] = 32'h12345678;
        tick();
        check("rdw_after", 64'(data_out1), 64'h12345678);

        // be=0 write is a no-op
        re = 0;
        wr(5'd3, 32'h0, 4'h0);
        re = 1; read1 = 3;
        tick();
        check("be_zero_noop", 64'(data_out1), 64'h12345678);

        // Out-of-range write and read
        we = 1; write = 20; data_in = 32'hFFFFFFFF; be = 4'hF;
        re = 1; read1 = 0; read2 = 17;
        tick();
        we = 0; re = 0;
        check("oor_err", 64'(addr_err), 64'd1);
        check("oor_p2_zero", {rd_valid, data_out2}, {31'd0, 1'b1, 32'd0});
        check("oor_p1", 64'(data_out1), 64'h00BB00DD);
        tick();
        check("oor_err_pulse", 64'(addr_err), 64'd0);
        for (int a = 0; a < 16; a++) begin
            re = 1; read1 = 5'(a); read2 = 5'(15 - a);
            tick();
            check($sformatf("oor_scan_%0d", a), {data_out1, data_out2}, {model[a], model[15 - a]});
            check($sformatf("oor_scan_err_%0d", a), 64'(addr_err), 64'd0);
        end
        re = 0;

        // Software clear ignores accesses while busy
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        re = 1; read1 = 5;
        tick();
        check("fill5", 64'(data_out1), 64'hDEADBEEF);
        re = 0; clear_req = 1;
        tick();
        clear_req = 0;
        check("sw_clr_busy", 64'(busy), 64'd1);
        we = 1; write = 5; data_in = 32'h11111111; be = 4'hF;
        re = 1; read1 = 5; read2 = 5;
        count_busy(n, rv_seen);
        we = 0; re = 0;
        check("sw_clr_len", 64'(n), 64'd16);
        check("sw_clr_rv", 64'(rv_seen), 64'd0);
        re = 1; read1 = 5; read2 = 0;
        tick();
        re = 0;
        check("sw_clr_rd5", {data_out1, data_out2}, 64'd0);
        check("sw_clr_rv_after", 64'(rd_valid), 64'd1);

        // Reset in mid-clear restarts the full sequence
        wr(5'd15, 32'hCAFEF00D, 4'hF);
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int i = 0; i < 7; i++) tick();
        #2;
        reset = 1;
        #1;
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_outs", {rd_valid, data_out1}, 64'd0);
        tick();
        tick();
        check("midrst_busy2", 64'(busy), 64'd1);
        reset = 0;
        count_busy(n, rv_seen);
        check("midrst_clr_len", 64'(n), 64'd16);
        re = 1; read1 = 15; read2 = 3;
        tick();
        re = 0;
        check("midrst_rd", {data_out1, data_out2}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
